// File: rtl/tail_light_seq_if.sv
// Lamp sequencer request/lamp bundle: turn/hazard/brake requests and step period in, lamp banks and busy out.
// Pure wiring; the slave side (sequencer) samples requests on clk and drives lamps from registered state only.
interface tail_light_seq_if #(
  parameter int N     = 3,
  parameter int DIV_W = 4
);
  logic             l;
  logic             r;
  logic             haz;
  logic             brake;
  logic [DIV_W-1:0] div;
  logic [N-1:0]     la;
  logic [N-1:0]     ra;
  logic             busy;

  modport master (
    output l, r, haz, brake, div,
    input  la, ra, busy
  );

  modport slave (
    input  l, r, haz, brake, div,
    output la, ra, busy
  );
endinterface

// File: rtl/tail_light_seq.sv
// Tail-light sequencer: thermometer sweep of N lamps per side, each step div+1 cycles, brake fill on idle sides.
// Lamps and busy are a Moore decode of registered state (one-cycle request-to-lamp latency); no backpressure.
module tail_light_seq #(
  parameter int N     = 3,
  parameter int DIV_W = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  tail_light_seq_if.slave bus
);

  localparam int K_W = $clog2(N + 1);
  localparam logic [K_W-1:0] K_ONE = K_W'(1);
  localparam logic [K_W-1:0] K_LAST = K_W'(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEFT,
    S_RIGHT,
    S_HAZ
  } state_t;

  state_t           r_state;
  logic [K_W-1:0]   r_k;
  logic [DIV_W-1:0] r_cnt;
  logic             r_brake_q;

  state_t           w_state_nxt;
  logic [K_W-1:0]   w_k_nxt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic             w_tick;
  logic [N-1:0]     w_therm;
  logic [N-1:0]     w_fill;
  logic [N-1:0]     w_la;
  logic [N-1:0]     w_ra;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_k       <= K_ONE;
      r_cnt     <= '0;
      r_brake_q <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_k       <= w_k_nxt;
      r_cnt     <= w_cnt_nxt;
      r_brake_q <= bus.brake;
    end
  end

  // >= rather than == so a div lowered mid-step ends the step instead of wrapping
  assign w_tick = (r_cnt >= bus.div);

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_k_nxt   = K_ONE;
        if (bus.haz || (bus.l && bus.r)) begin
          w_state_nxt = S_HAZ;
        end else if (bus.l) begin
          w_state_nxt = S_LEFT;
        end else if (bus.r) begin
          w_state_nxt = S_RIGHT;
        end
      end
      default: begin
        if (w_tick) begin
          w_cnt_nxt = '0;
          if (bus.haz && (r_state != S_HAZ)) begin
            w_state_nxt = S_HAZ;
            w_k_nxt     = K_ONE;
          end else if (r_k < K_LAST) begin
            w_k_nxt = r_k + K_ONE;
          end else begin
            w_state_nxt = S_IDLE;
            w_k_nxt     = K_ONE;
          end
        end else begin
          w_cnt_nxt = r_cnt + DIV_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    w_therm = '0;
    for (int i = 0; i < N; i++) begin
      w_therm[i] = (i < int'(r_k));
    end
  end

  // Sides not being swept show the brake level; hazard overrides brake on both sides
  assign w_fill = r_brake_q ? {N{1'b1}} : {N{1'b0}};

  always_comb begin
    w_la = w_fill;
    w_ra = w_fill;
    case (r_state)
      S_LEFT:  w_la = w_therm;
      S_RIGHT: w_ra = w_therm;
      S_HAZ: begin
        w_la = w_therm;
        w_ra = w_therm;
      end
      default: ;
    endcase
  end

  assign bus.la   = w_la;
  assign bus.ra   = w_ra;
  assign bus.busy = (r_state != S_IDLE);

endmodule

// File: doc/tail_light_seq.md
TAIL_LIGHT_SEQ -- requirements
Module: tail_light_seq

Interface
REQ-001 SHALL have parameter N, default 3, number of lamps per side (legal 1..16).
REQ-002 SHALL have parameter DIV_W, default 4, width of the step-period input (legal 1..16).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port l  input  1  left-turn request.
REQ-006 SHALL have port r  input  1  right-turn request.
REQ-007 SHALL have port haz  input  1  hazard request.
REQ-008 SHALL have port brake  input  1  brake lamp request.
REQ-009 SHALL have port div  input  DIV_W  step period minus one, in clk cycles.
REQ-010 SHALL have port la  output  N  left lamps; bit 0 is innermost.
REQ-011 SHALL have port ra  output  N  right lamps; bit 0 is innermost.
REQ-012 SHALL have port busy  output  1  high while any sequence is active.

Function
REQ-013 SHALL implement states IDLE, LEFT, RIGHT and HAZ, with a step counter k in 1..N.
REQ-014 SHALL keep a prescaler cnt; in a sequence state, tick = (cnt >= div); on tick cnt <- 0, else cnt <- cnt+1; cnt SHALL be held at 0 in IDLE.
REQ-015 SHALL evaluate requests in IDLE every cycle, with priority haz or (l and r) -> HAZ; else l -> LEFT; else r -> RIGHT; else stay IDLE; the entered state SHALL start at k=1.
REQ-016 SHALL advance on tick in LEFT/RIGHT/HAZ: if k<N then k <- k+1; if k=N then go to IDLE.
REQ-017 SHALL ignore l and r while in LEFT, RIGHT or HAZ.
REQ-018 SHALL let haz=1 at a tick in LEFT or RIGHT override REQ-016: go to HAZ, k=1.
REQ-019 SHALL hold each step for exactly div+1 cycles; IDLE SHALL last at least 1 cycle between sequences (div=0, N=3 gives the sequence IDLE,1,2,3,IDLE).
REQ-020 SHALL tolerate div changing mid-step: the >= compare ends the step at the next edge if cnt already exceeds the new div; there SHALL be no wrap.
REQ-021 SHALL drive lamps as a Moore decode of the registered state with no combinational input-to-output path; step k lights the low k bits (thermometer code).
REQ-022 SHALL drive lamps per state: LEFT drives la=therm(k); RIGHT drives ra=therm(k); HAZ drives la=ra=therm(k); IDLE drives both 0.
REQ-023 SHALL register brake into brake_q each cycle; when brake_q=1, any side not being sequenced SHALL be all-ones; IDLE with brake_q SHALL drive both sides all-ones; HAZ SHALL ignore brake_q.
REQ-024 SHALL drive busy = (state != IDLE), registered-state decode.

Reset
REQ-025 SHALL, while reset_n=0, immediately force state=IDLE, k=1, cnt=0, brake_q=0, la=0, ra=0 and busy=0, independent of clk.
REQ-026 SHALL abandon any sequence on reset mid-operation; after release the first rising edge SHALL evaluate requests per REQ-015.

Verification
REQ-027 SHALL cover: N=3, div=0, l=1 held -> la=001,011,111,000 repeating; ra=000 throughout.
REQ-028 SHALL cover: N=3, div=2, r=1 for 1 cycle -> ra=001 x3 cycles, 011 x3, 111 x3, then 000; busy high for 9 cycles.
REQ-029 SHALL cover: N=3, div=0, l=r=1 -> la=ra=001,011,111,000; identical result with haz=1 alone.
REQ-030 SHALL cover: N=3, div=1, LEFT at k=2, haz=1 at tick -> next la=ra=001, then HAZ completes.
REQ-031 SHALL cover: N=4, div=0, l=1 and brake=1 -> ra=1111 throughout; la=0001,0011,0111,1111, then 1111 in IDLE.
REQ-032 SHALL cover: reset_n=0 asserted mid-HAZ between clock edges -> la=ra=0, busy=0 before the next edge; resume from IDLE after release.
